key_press_classifier: RTL and testbench

- Consumes the debounced rise/fall pulses from the 15 ms key debouncer stage (S3 path).
- Classifies each key gesture as short press, long press or double click.
- Emits one single-cycle pulse per classified gesture.
- Also holds a latched 2-bit code of the last gesture for LEDs/display logic downstream.

---
 rtl/key_pkg.sv | 28 ++
 rtl/key_press_classifier.sv | 142 ++++++++++++++
 tb/tb_key_press_classifier.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared constants for the key input path: classifier state codes, gesture event codes
// and default 100 MHz timing values.
package key_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRESS1    = 3'd1;
  localparam logic [2:0] ST_LONG_HELD = 3'd2;
  localparam logic [2:0] ST_WAIT2     = 3'd3;
  localparam logic [2:0] ST_PRESS2    = 3'd4;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_SHORT  = 2'd1,
    EV_LONG   = 2'd2,
    EV_DOUBLE = 2'd3
  } key_event_e;

  localparam int unsigned CLK_HZ           = 100_000_000;
  localparam int unsigned DEBOUNCE_CNT_MAX = 1_500_000;   // 15 ms
  localparam int unsigned LONG_CNT_DEF     = 100_000_000; // 1 s
  localparam int unsigned DCLICK_CNT_DEF   = 30_000_000;  // 300 ms
  localparam int unsigned CNT_W_DEF        = 27;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return ms * (CLK_HZ / 1000);
  endfunction

endpackage

// File: rtl/key_press_classifier.sv
// Classifies debounced press/release pulses into short, long and double-click gestures,
// emitting one registered pulse per gesture and latching the last gesture code.
module key_press_classifier
  import key_pkg::*;
#(
  parameter int unsigned LONG_CNT   = LONG_CNT_DEF,
  parameter int unsigned DCLICK_CNT = DCLICK_CNT_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rise_pulse,
  input  logic       fall_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       double_pulse,
  output logic [1:0] last_event,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_short;
  logic             r_long;
  logic             r_double;
  key_event_e       r_last;

  logic [2:0]       w_state_nxt;
  logic             w_short_nxt;
  logic             w_long_nxt;
  logic             w_double_nxt;
  key_event_e       w_last_nxt;
  logic             w_cnt_clr;
  logic             w_cnt_inc;

  // Simultaneous rise and fall cancel each other out.
  logic w_rise;
  logic w_fall;
  assign w_rise = rise_pulse & ~fall_pulse;
  assign w_fall = fall_pulse & ~rise_pulse;

  logic w_long_hit;
  logic w_dclick_hit;
  assign w_long_hit   = (r_cnt == LONG_LAST);
  assign w_dclick_hit = (r_cnt == DCLICK_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_short_nxt  = 1'b0;
    w_long_nxt   = 1'b0;
    w_double_nxt = 1'b0;
    w_last_nxt   = r_last;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_PRESS1;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_PRESS1: begin
        // A release on the terminal cycle takes priority over the long decision.
        if (w_fall) begin
          w_state_nxt = ST_WAIT2;
          w_cnt_clr   = 1'b1;
        end else if (w_long_hit) begin
          w_state_nxt = ST_LONG_HELD;
          w_long_nxt  = 1'b1;
          w_last_nxt  = EV_LONG;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT2: begin
        // A second press on the expiry cycle still counts as a double click.
        if (w_rise) begin
          w_state_nxt = ST_PRESS2;
        end else if (w_dclick_hit) begin
          w_state_nxt = ST_IDLE;
          w_short_nxt = 1'b1;
          w_last_nxt  = EV_SHORT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (w_fall) begin
          w_state_nxt  = ST_IDLE;
          w_double_nxt = 1'b1;
          w_last_nxt   = EV_DOUBLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_last   <= EV_NONE;
    end else begin
      r_state  <= w_state_nxt;
      r_short  <= w_short_nxt;
      r_long   <= w_long_nxt;
      r_double <= w_double_nxt;
      r_last   <= w_last_nxt;
    end
  end

  // Increment is only requested below the terminal value, so the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign short_pulse  = r_short;
  assign long_pulse   = r_long;
  assign double_pulse = r_double;
  assign last_event   = r_last;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_key_press_classifier.sv
// Bench for key_press_classifier: directed gestures and boundaries, async reset, then
// random gestures, all checked against a timestamp-based gesture model.
module tb_key_press_classifier;

  localparam int unsigned LONG   = 20;
  localparam int unsigned DCLICK = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rise_pulse = 1'b0;
  logic       fall_pulse = 1'b0;
  logic       short_pulse;
  logic       long_pulse;
  logic       double_pulse;
  logic [1:0] last_event;
  logic       busy;

  key_press_classifier #(
    .LONG_CNT  (LONG),
    .DCLICK_CNT(DCLICK),
    .CNT_W     (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .double_pulse(double_pulse),
    .last_event  (last_event),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Gesture model: timestamps of the first press and release instead of a counter.
  int   t_press;
  int   t_rel;
  bit   m_long;
  bit   m_second;
  bit   e_short, e_long, e_double;
  logic [1:0] e_last;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset(input bit clear_last);
    t_press  = -1;
    t_rel    = -1;
    m_long   = 1'b0;
    m_second = 1'b0;
    e_short  = 1'b0;
    e_long   = 1'b0;
    e_double = 1'b0;
    if (clear_last) e_last = 2'd0;
  endtask

  task automatic model_edge(input bit r_in, input bit f_in);
    bit r, f;
    r = r_in & ~f_in;
    f = f_in & ~r_in;
    e_short  = 1'b0;
    e_long   = 1'b0;
    e_double = 1'b0;
    if (t_press < 0) begin
      if (r) t_press = cyc;
    end else if (m_long) begin
      if (f) model_reset(1'b0);
    end else if (m_second) begin
      if (f) begin
        model_reset(1'b0);
        e_double = 1'b1;
        e_last   = 2'd3;
      end
    end else if (t_rel < 0) begin
      if (f) t_rel = cyc;
      else if (cyc - t_press == int'(LONG)) begin
        m_long = 1'b1;
        e_long = 1'b1;
        e_last = 2'd2;
      end
    end else begin
      if (r) m_second = 1'b1;
      else if (cyc - t_rel == int'(DCLICK)) begin
        model_reset(1'b0);
        e_short = 1'b1;
        e_last  = 2'd1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".short"},  {7'd0, short_pulse},  {7'd0, e_short});
    chk({tag, ".long"},   {7'd0, long_pulse},   {7'd0, e_long});
    chk({tag, ".double"}, {7'd0, double_pulse}, {7'd0, e_double});
    chk({tag, ".last"},   {6'd0, last_event},   {6'd0, e_last});
    chk({tag, ".busy"},   {7'd0, busy},         {7'd0, (t_press >= 0)});
  endtask

  task automatic step(input bit r, input bit f);
    rise_pulse = r;
    fall_pulse = f;
    @(posedge clk);
    cyc++;
    model_edge(r, f);
    #1;
    rise_pulse = 1'b0;
    fall_pulse = 1'b0;
    check_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    model_reset(1'b1);
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Short press: release at t0+5, short at t0+15.
    step(1, 0); idle(4); step(0, 1); idle(10);
    chk("short_at_15", {7'd0, short_pulse}, 8'd1);
    idle(1);
    chk("short_busy_after", {7'd0, busy}, 8'd0);
    chk("short_last", {6'd0, last_event}, 8'd1);

    // Long press: long at t0+20, release at t0+40 yields nothing.
    step(1, 0); idle(20);
    chk("long_at_20", {7'd0, long_pulse}, 8'd1);
    idle(1);
    chk("long_single", {7'd0, long_pulse}, 8'd0);
    idle(18); step(0, 1); idle(12);
    chk("long_last", {6'd0, last_event}, 8'd2);

    // Double click: release t0+3, press t0+8, release t0+12.
    step(1, 0); idle(2); step(0, 1); idle(4); step(1, 0); idle(3); step(0, 1);
    chk("double_pulse", {7'd0, double_pulse}, 8'd1);
    idle(12);
    chk("double_last", {6'd0, last_event}, 8'd3);

    // Release on the long terminal cycle wins; short follows.
    step(1, 0); idle(19); step(0, 1);
    chk("edge_long_none", {7'd0, long_pulse}, 8'd0);
    idle(10);
    chk("edge_long_short", {7'd0, short_pulse}, 8'd1);
    idle(2);

    // Second press on the gap expiry cycle wins; double on release.
    step(1, 0); idle(1); step(0, 1); idle(9); step(1, 0);
    chk("edge_gap_noshort", {7'd0, short_pulse}, 8'd0);
    idle(25); step(0, 1);
    chk("edge_gap_double", {7'd0, double_pulse}, 8'd1);
    idle(2);

    // Simultaneous rise/fall in idle.
    step(1, 1);
    chk("both_idle_busy", {7'd0, busy}, 8'd0);
    idle(3);

    // Async reset in the gap window with five cycles elapsed.
    step(1, 0); idle(2); step(0, 1); idle(5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset(1'b1);
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
    idle(15);
    step(1, 0); idle(3); step(0, 1); idle(10);
    chk("post_rst_short", {7'd0, short_pulse}, 8'd1);
    idle(2);

    // Random gestures, occasionally with a cancelled rise/fall cycle.
    for (int g = 0; g < 60; g++) begin
      idle(int'($urandom_range(0, 14)));
      if ($urandom_range(0, 7) == 0) step(1, 1);
      step(1, 0);
      idle(int'($urandom_range(0, 26)));
      if ($urandom_range(0, 7) == 0) step(1, 1);
      step(0, 1);
    end
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
